// File: rtl/tt_pad_cfg_loader.sv
// Pad-ring configuration sequencer: fetches one word per pad from a config table,
// shifts it MSB-first into the serial pad chain on a divided clock, then latches.
module tt_pad_cfg_loader #(
    parameter int N_PADS = 64,
    parameter int CFG_W  = 16,
    parameter int DIV    = 2,
    parameter int AW     = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             tbl_rd,
    output logic [AW-1:0]    tbl_addr,
    input  logic [CFG_W-1:0] tbl_data,
    output logic             cfg_sclk,
    output logic             cfg_sdata,
    output logic             cfg_latch
);

    localparam int BW = (CFG_W > 1) ? $clog2(CFG_W) : 1;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [AW-1:0] PAD_LAST = AW'(N_PADS - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(CFG_W - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_WAIT     = 3'd2,
        S_SHIFT_LO = 3'd3,
        S_SHIFT_HI = 3'd4,
        S_LATCH    = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    state_t             state_r, state_s;
    logic [AW-1:0]      pad_cnt_r, pad_cnt_s;
    logic [BW-1:0]      bit_cnt_r, bit_cnt_s;
    logic [DW-1:0]      div_cnt_r, div_cnt_s;
    logic [CFG_W-1:0]   sreg_r, sreg_s;
    logic [AW-1:0]      tbl_addr_r, tbl_addr_s;
    logic               busy_r, done_r, tbl_rd_r, sclk_r, sdata_r, latch_r;
    logic               busy_s, done_s, tbl_rd_s, sclk_s, sdata_s, latch_s;
    logic               phase_end_s;

    // Next-state, counter and shift-register logic; outputs decoded from the next state
    always_comb begin
        state_s     = state_r;
        pad_cnt_s   = pad_cnt_r;
        bit_cnt_s   = bit_cnt_r;
        div_cnt_s   = div_cnt_r;
        sreg_s      = sreg_r;
        tbl_addr_s  = tbl_addr_r;
        phase_end_s = (div_cnt_r == DIV_LAST);

        case (state_r)
            S_IDLE: begin
                if (start && !abort) begin
                    state_s = S_FETCH;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_FETCH: begin
                state_s = S_WAIT;
            end
            S_WAIT: begin
                sreg_s    = tbl_data;
                bit_cnt_s = BIT_LAST;
                div_cnt_s = '0;
                state_s   = S_SHIFT_LO;
            end
            S_SHIFT_LO: begin
                if (phase_end_s) begin
                    div_cnt_s = '0;
                    state_s   = S_SHIFT_HI;
                end else begin
                    div_cnt_s = div_cnt_r + DW'(1);
                end
            end
            S_SHIFT_HI: begin
                if (phase_end_s) begin
                    div_cnt_s = '0;
                    sreg_s    = sreg_r << 1;
                    if (bit_cnt_r != '0) begin
                        bit_cnt_s = bit_cnt_r - BW'(1);
                        state_s   = S_SHIFT_LO;
                    end else if (pad_cnt_r != '0) begin
                        pad_cnt_s = pad_cnt_r - AW'(1);
                        state_s   = S_FETCH;
                    end else begin
                        state_s   = S_LATCH;
                    end
                end else begin
                    div_cnt_s = div_cnt_r + DW'(1);
                end
            end
            S_LATCH: begin
                if (phase_end_s) begin
                    div_cnt_s = '0;
                    state_s   = S_DONE;
                end else begin
                    div_cnt_s = div_cnt_r + DW'(1);
                end
            end
            S_DONE: begin
                pad_cnt_s = PAD_LAST;
                state_s   = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase

        // Abort drops straight to idle without latching, so pads keep their old setup
        if (abort && (state_r != S_IDLE)) begin
            state_s   = S_IDLE;
            pad_cnt_s = PAD_LAST;
            bit_cnt_s = '0;
            div_cnt_s = '0;
        end else begin
            state_s = state_s;
        end

        if (state_s == S_FETCH) begin
            tbl_addr_s = pad_cnt_s;
        end else begin
            tbl_addr_s = tbl_addr_r;
        end

        busy_s   = (state_s == S_FETCH) || (state_s == S_WAIT) || (state_s == S_SHIFT_LO) ||
                   (state_s == S_SHIFT_HI) || (state_s == S_LATCH);
        done_s   = (state_s == S_DONE);
        tbl_rd_s = (state_s == S_FETCH);
        sclk_s   = (state_s == S_SHIFT_HI);
        latch_s  = (state_s == S_LATCH);
        if ((state_s == S_SHIFT_LO) || (state_s == S_SHIFT_HI)) begin
            sdata_s = sreg_s[CFG_W-1];
        end else begin
            sdata_s = 1'b0;
        end
    end

    // State, counters, shift register and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            pad_cnt_r  <= PAD_LAST;
            bit_cnt_r  <= '0;
            div_cnt_r  <= '0;
            sreg_r     <= '0;
            tbl_addr_r <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            tbl_rd_r   <= 1'b0;
            sclk_r     <= 1'b0;
            sdata_r    <= 1'b0;
            latch_r    <= 1'b0;
        end else begin
            state_r    <= state_s;
            pad_cnt_r  <= pad_cnt_s;
            bit_cnt_r  <= bit_cnt_s;
            div_cnt_r  <= div_cnt_s;
            sreg_r     <= sreg_s;
            tbl_addr_r <= tbl_addr_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            tbl_rd_r   <= tbl_rd_s;
            sclk_r     <= sclk_s;
            sdata_r    <= sdata_s;
            latch_r    <= latch_s;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign tbl_rd    = tbl_rd_r;
    assign tbl_addr  = tbl_addr_r;
    assign cfg_sclk  = sclk_r;
    assign cfg_sdata = sdata_r;
    assign cfg_latch = latch_r;

endmodule

// File: tb/tb_tt_pad_cfg_loader.sv
// Bench for tt_pad_cfg_loader: a small (2x4, DIV=1) and a default instance,
// each checked against a chain model rebuilt from the observed serial stream.
module tb_tt_pad_cfg_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- small instance ----------------
    logic       s_start = 1'b0, s_abort = 1'b0;
    logic       s_busy, s_done, s_rd, s_sclk, s_sdata, s_latch;
    logic [0:0] s_addr;
    logic [3:0] s_tdata;
    logic [3:0] s_tbl [0:1];

    tt_pad_cfg_loader #(.N_PADS(2), .CFG_W(4), .DIV(1), .AW(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(s_start), .abort(s_abort),
        .busy(s_busy), .done(s_done), .tbl_rd(s_rd), .tbl_addr(s_addr),
        .tbl_data(s_tdata), .cfg_sclk(s_sclk), .cfg_sdata(s_sdata), .cfg_latch(s_latch)
    );

    always @(posedge clk) if (s_rd === 1'b1) s_tdata <= s_tbl[s_addr];

    int s_busy_n = 0, s_done_n = 0, s_latch_n = 0, s_rd_n = 0, s_viol = 0;
    int s_latch_at = 0, s_latch_cyc = 0, s_done_cyc = 0, cyc = 0;
    bit s_bits[$];
    int s_addrs[$];
    logic s_psclk = 1'b0, s_psdata = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (s_busy === 1'b1) s_busy_n <= s_busy_n + 1;
        if (s_done === 1'b1) begin s_done_n <= s_done_n + 1; s_done_cyc <= cyc; end
        if (s_latch === 1'b1) begin
            s_latch_n <= s_latch_n + 1; s_latch_cyc <= cyc; s_latch_at <= s_bits.size();
        end
        if (s_rd === 1'b1) begin s_rd_n <= s_rd_n + 1; s_addrs.push_back(int'(s_addr)); end
        if (s_sclk === 1'b1 && s_psclk === 1'b0) s_bits.push_back(s_sdata);
        if (s_sclk === 1'b1 && s_psclk === 1'b1 && s_sdata !== s_psdata) s_viol <= s_viol + 1;
        s_psclk  <= s_sclk;
        s_psdata <= s_sdata;
    end

    // ---------------- default instance ----------------
    logic        d_start = 1'b0, d_abort = 1'b0;
    logic        d_busy, d_done, d_rd, d_sclk, d_sdata, d_latch;
    logic [5:0]  d_addr;
    logic [15:0] d_tdata;
    logic [15:0] d_tbl [0:63];

    tt_pad_cfg_loader dut_d (
        .clk(clk), .rst_n(rst_n), .start(d_start), .abort(d_abort),
        .busy(d_busy), .done(d_done), .tbl_rd(d_rd), .tbl_addr(d_addr),
        .tbl_data(d_tdata), .cfg_sclk(d_sclk), .cfg_sdata(d_sdata), .cfg_latch(d_latch)
    );

    always @(posedge clk) if (d_rd === 1'b1) d_tdata <= d_tbl[d_addr];

    int d_busy_n = 0, d_done_n = 0, d_latch_n = 0, d_viol = 0;
    bit d_bits[$];
    logic d_psclk = 1'b0, d_psdata = 1'b0;

    always @(negedge clk) begin
        if (d_busy === 1'b1) d_busy_n <= d_busy_n + 1;
        if (d_done === 1'b1) d_done_n <= d_done_n + 1;
        if (d_latch === 1'b1) d_latch_n <= d_latch_n + 1;
        if (d_sclk === 1'b1 && d_psclk === 1'b0) d_bits.push_back(d_sdata);
        if (d_sclk === 1'b1 && d_psclk === 1'b1 && d_sdata !== d_psdata) d_viol <= d_viol + 1;
        d_psclk  <= d_sclk;
        d_psdata <= d_sdata;
    end

    // ---------------- helpers ----------------
    int sb_bits, sb_busy, sb_done, sb_latch, sb_rd;

    task automatic snap_s();
        sb_bits = s_bits.size(); sb_busy = s_busy_n; sb_done = s_done_n;
        sb_latch = s_latch_n; sb_rd = s_rd_n;
    endtask

    task automatic pulse_start_s();
        @(negedge clk); s_start = 1'b1;
        @(negedge clk); s_start = 1'b0;
    endtask

    task automatic wait_idle_s(input string tag);
        int n = 0;
        while (s_busy === 1'b1 && n < 200) begin @(negedge clk); n++; end
        chk({tag, "_timeout"}, 64'(n < 200), 64'd1);
        repeat (3) @(negedge clk);
    endtask

    // Rebuild the 8-bit chain from the observed edges and compare each pad with the table
    task automatic check_load_s(input string tag);
        logic [7:0] chain = 8'h00;
        for (int i = sb_bits; i < s_bits.size(); i++) chain = {chain[6:0], s_bits[i]};
        chk({tag, "_edges"}, 64'(s_bits.size() - sb_bits), 64'd8);
        for (int p = 0; p < 2; p++) chk($sformatf("%s_pad%0d", tag, p), 64'(chain[p*4 +: 4]), 64'(s_tbl[p]));
        chk({tag, "_busy_cycles"}, 64'(s_busy_n - sb_busy), 64'd21);
        chk({tag, "_latch_cycles"}, 64'(s_latch_n - sb_latch), 64'd1);
        chk({tag, "_latch_after_edges"}, 64'(s_latch_at - sb_bits), 64'd8);
        chk({tag, "_done_pulses"}, 64'(s_done_n - sb_done), 64'd1);
        chk({tag, "_done_after_latch"}, 64'(s_done_cyc - s_latch_cyc), 64'd1);
        chk({tag, "_rd_cycles"}, 64'(s_rd_n - sb_rd), 64'd2);
        chk({tag, "_sdata_stable"}, 64'(s_viol), 64'd0);
    endtask

    task automatic rand_tbl_s();
        for (int i = 0; i < 2; i++) s_tbl[i] = 4'($urandom);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int db_bits, db_busy, db_done, db_latch, n, hi;
        logic [7:0] seq;
        logic [1023:0] dchain;

        s_tbl[0] = 4'hA; s_tbl[1] = 4'h5;
        for (int i = 0; i < 64; i++) d_tbl[i] = 16'($urandom);
        repeat (3) @(negedge clk);
        chk("reset_s_outs", {58'd0, s_busy, s_done, s_rd, s_sclk, s_sdata, s_latch}, 64'd0);
        chk("reset_s_addr", 64'(s_addr), 64'd0);
        chk("reset_d_outs", {58'd0, d_busy, d_done, d_rd, d_sclk, d_sdata, d_latch}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Test 1/2: fixed table, exact bit order and read addresses
        snap_s();
        pulse_start_s();
        chk("t1_busy_rises", 64'(s_busy), 64'd1);
        wait_idle_s("t1");
        seq = 8'h00;
        for (int i = 0; i < 8; i++) seq = {seq[6:0], s_bits[sb_bits + i]};
        chk("t1_seq", 64'(seq), 64'h5A);
        check_load_s("t1");
        chk("t2_addr_first", 64'(s_addrs[s_addrs.size() - 2]), 64'd1);
        chk("t2_addr_last", 64'(s_addrs[s_addrs.size() - 1]), 64'd0);

        // Test 4: abort during the 5th high phase, then a clean reload
        rand_tbl_s();
        snap_s();
        pulse_start_s();
        hi = 0;
        for (int i = 0; i < 100 && hi < 5; i++) begin
            @(negedge clk);
            if (s_sclk === 1'b1) hi++;
        end
        chk("t4_reach_hi5", 64'(hi), 64'd5);
        s_abort = 1'b1;
        @(negedge clk);
        s_abort = 1'b0;
        chk("t4_abort_outs", {59'd0, s_busy, s_sclk, s_sdata, s_latch, s_rd}, 64'd0);
        repeat (5) @(negedge clk);
        chk("t4_no_latch", 64'(s_latch_n - sb_latch), 64'd0);
        chk("t4_no_done", 64'(s_done_n - sb_done), 64'd0);
        chk("t4_edges_before_abort", 64'(s_bits.size() - sb_bits), 64'd5);
        rand_tbl_s();
        snap_s();
        pulse_start_s();
        wait_idle_s("t4r");
        check_load_s("t4r");

        // Test 5: start held mid-load is ignored; start+abort in idle does nothing
        rand_tbl_s();
        snap_s();
        pulse_start_s();
        repeat (6) @(negedge clk);
        s_start = 1'b1;
        repeat (4) @(negedge clk);
        s_start = 1'b0;
        wait_idle_s("t5");
        check_load_s("t5");
        snap_s();
        @(negedge clk); s_start = 1'b1; s_abort = 1'b1;
        @(negedge clk); s_start = 1'b0; s_abort = 1'b0;
        chk("t5_sa_busy", 64'(s_busy), 64'd0);
        repeat (4) @(negedge clk);
        chk("t5_sa_busy_cycles", 64'(s_busy_n - sb_busy), 64'd0);
        chk("t5_sa_rd_cycles", 64'(s_rd_n - sb_rd), 64'd0);

        // Test 6: one-cycle reset in the middle of shifting
        rand_tbl_s();
        snap_s();
        pulse_start_s();
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t6_rst_outs", {57'd0, s_busy, s_done, s_rd, s_sclk, s_sdata, s_latch, s_addr}, 64'd0);
        repeat (4) @(negedge clk);
        chk("t6_no_latch", 64'(s_latch_n - sb_latch), 64'd0);
        chk("t6_no_done", 64'(s_done_n - sb_done), 64'd0);
        rand_tbl_s();
        snap_s();
        pulse_start_s();
        wait_idle_s("t6r");
        check_load_s("t6r");
        chk("t6r_first_addr", 64'(s_addrs[s_addrs.size() - 2]), 64'd1);

        // Test 3: default configuration with a random table
        db_bits = d_bits.size(); db_busy = d_busy_n; db_done = d_done_n; db_latch = d_latch_n;
        @(negedge clk); d_start = 1'b1;
        @(negedge clk); d_start = 1'b0;
        n = 0;
        while (d_busy === 1'b1 && n < 6000) begin @(negedge clk); n++; end
        chk("t3_timeout", 64'(n < 6000), 64'd1);
        repeat (3) @(negedge clk);
        chk("t3_edges", 64'(d_bits.size() - db_bits), 64'd1024);
        chk("t3_busy_cycles", 64'(d_busy_n - db_busy), 64'd4226);
        chk("t3_done_pulses", 64'(d_done_n - db_done), 64'd1);
        chk("t3_latch_cycles", 64'(d_latch_n - db_latch), 64'd2);
        chk("t3_sdata_stable", 64'(d_viol), 64'd0);
        dchain = '0;
        for (int i = db_bits; i < d_bits.size(); i++) dchain = {dchain[1022:0], d_bits[i]};
        for (int p = 0; p < 64; p++) chk($sformatf("t3_pad%0d", p), 64'(dchain[p*16 +: 16]), 64'(d_tbl[p]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
